// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-side bundle: instruction-memory request/response, decode hand-off and branch/jump redirect.
interface pc_fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_ack, imem_rdata, inst_ready, redirect_valid, redirect_target
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_ack, imem_rdata, inst_ready, redirect_valid, redirect_target
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// PC owner and fetch sequencer: requests words from imem, holds each for decode, applies redirects.
// Optional macro PCSEQ_ALIGN_CHECK_EN: misaligned redirects trap to HALT and pulse misalign_err.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 halt,
  pc_fetch_sequencer_if.master bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     fetch_count
`ifdef PCSEQ_ALIGN_CHECK_EN
  ,
  output logic                 misalign_err
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pending_q, pending_d;
  logic [31:0]      inst_q, inst_d;
  logic [31:0]      inst_pc_q, inst_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             req_q, req_d;
  logic             valid_q, valid_d;
  logic             flush_q, flush_d;
  logic             trap_q, trap_d;
  logic             halt_req_q, halt_req_d;
  logic             ack, gap, stop;
  logic [31:0]      target;
  logic             target_bad;

`ifdef PCSEQ_ALIGN_CHECK_EN
  assign target     = bus.redirect_target;
  assign target_bad = bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);
`else
  assign target     = {bus.redirect_target[31:2], 2'b00};
  assign target_bad = 1'b0;
`endif

  // An ack only counts while our request is actually on the bus; late or gap-cycle acks are ignored.
  assign ack  = req_q && bus.imem_ack;
  assign stop = halt || halt_req_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pending_d  = pending_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    count_d    = count_q;
    flush_d    = flush_q;
    trap_d     = trap_q;
    halt_req_d = halt_req_q;
    gap        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.redirect_valid) begin
          if (target_bad) state_d = HALT;
          else            pc_d    = target;
        end else if (halt) begin
          state_d = HALT;
        end else if (start) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (halt) halt_req_d = 1'b1;
        if (ack) begin
          if (bus.redirect_valid || flush_q) begin
            // Stale word: drop it and drop req for one cycle before presenting the new PC.
            flush_d = 1'b0;
            trap_d  = 1'b0;
            if (target_bad || trap_q) begin
              state_d = HALT;
            end else begin
              pc_d = bus.redirect_valid ? target : pending_q;
              gap  = 1'b1;
            end
          end else begin
            inst_d    = bus.imem_rdata;
            inst_pc_d = pc_q;
            state_d   = HOLD;
          end
        end else if (bus.redirect_valid) begin
          if (req_q) begin
            flush_d = 1'b1;
            if (target_bad) trap_d    = 1'b1;
            else            pending_d = target;
          end else if (target_bad) begin
            state_d = HALT;
          end else begin
            pc_d = target;
          end
        end
      end
      HOLD: begin
        if (halt) halt_req_d = 1'b1;
        if (bus.inst_ready) count_d = count_q + CNT_W'(1);
        if (bus.redirect_valid) begin
          if (target_bad) begin
            state_d = HALT;
          end else begin
            pc_d    = target;
            state_d = (bus.inst_ready && stop) ? HALT : REQ;
          end
        end else if (bus.inst_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = stop ? HALT : REQ;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: state_d = IDLE;
    endcase
    req_d   = (state_d == REQ) && !gap;
    valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      pending_q  <= '0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      count_q    <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
      trap_q     <= 1'b0;
      halt_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pending_q  <= pending_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      count_q    <= count_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      flush_q    <= flush_d;
      trap_q     <= trap_d;
      halt_req_q <= halt_req_d;
    end
  end

`ifdef PCSEQ_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = target_bad && (state_q != HALT);
  end

  always_ff @(posedge clock) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end

  assign misalign_err = misalign_q;
`endif

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = valid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign busy           = (state_q == REQ) || (state_q == HOLD);
  assign fetch_count    = count_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed scenarios plus a randomized instruction-stream model.
module tb_pc_fetch_sequencer;
  localparam int          CNT_W    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic             clock = 1'b0;
  logic             reset, start, halt;
  logic             busy;
  logic [CNT_W-1:0] fetch_count;
`ifdef PCSEQ_ALIGN_CHECK_EN
  logic             misalign_err;
`endif

  int checks = 0;
  int errors = 0;
  bit mem_auto, lat_rand;
  int wait_cnt, lat;

  pc_fetch_sequencer_if bus();

  pc_fetch_sequencer #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .start(start), .halt(halt), .bus(bus),
    .busy(busy), .fetch_count(fetch_count)
`ifdef PCSEQ_ALIGN_CHECK_EN
    , .misalign_err(misalign_err)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // One cycle: wait for the falling edge, then let the memory model answer any pending request.
  task automatic tick();
    @(negedge clock);
    if (mem_auto) begin
      if (bus.imem_req) begin
        if (wait_cnt >= lat) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = mem_word(bus.imem_addr);
          wait_cnt       = 0;
          lat            = lat_rand ? $urandom_range(0, 3) : 0;
        end else begin
          bus.imem_ack   = 1'b0;
          bus.imem_rdata = $urandom;
          wait_cnt++;
        end
      end else begin
        bus.imem_ack = 1'b0;
        wait_cnt     = 0;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; halt = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.inst_ready = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_target = '0;
    mem_auto = 1'b0; lat_rand = 1'b0; wait_cnt = 0; lat = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req: got %b expected 0", bus.imem_req); end
    if (bus.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b expected 0", bus.inst_valid); end
    if (bus.inst !== 32'h0) begin errors++; $display("[TB] FAIL rst_inst: got %h expected 0", bus.inst); end
    if (bus.inst_pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_inst_pc: got %h expected 0", bus.inst_pc); end
    if (fetch_count !== '0) begin errors++; $display("[TB] FAIL rst_count: got %0d expected 0", fetch_count); end
    if (bus.imem_addr !== RESET_PC || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_addr_busy: got %h/%b expected %h/0", bus.imem_addr, busy, RESET_PC);
    end
`ifdef PCSEQ_ALIGN_CHECK_EN
    checks++;
    if (misalign_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_misalign: got %b expected 0", misalign_err); end
`endif
  endtask

  task automatic test_sequential_fetch();
    int n_ack = 0;
    int n_hs = 0;
    do_reset();
    mem_auto = 1'b1; bus.inst_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int cyc = 0; cyc < 50 && n_hs < 3; cyc++) begin
      if (bus.imem_req && bus.imem_ack) begin
        checks++;
        if (bus.imem_addr !== 32'(n_ack * 4)) begin
          errors++; $display("[TB] FAIL t1_addr: got %h expected %h", bus.imem_addr, 32'(n_ack * 4));
        end
        n_ack++;
      end
      if (bus.inst_valid) begin
        checks += 2;
        if (bus.inst_pc !== 32'(n_hs * 4)) begin
          errors++; $display("[TB] FAIL t1_inst_pc: got %h expected %h", bus.inst_pc, 32'(n_hs * 4));
        end
        if (bus.inst !== mem_word(32'(n_hs * 4))) begin
          errors++; $display("[TB] FAIL t1_inst: got %h expected %h", bus.inst, mem_word(32'(n_hs * 4)));
        end
        n_hs++;
      end
      tick();
    end
    checks++;
    if (n_hs < 3) begin errors++; $display("[TB] FAIL t1_timeout: got %0d handshakes expected 3", n_hs); end
    checks++;
    if (fetch_count !== CNT_W'(3)) begin errors++; $display("[TB] FAIL t1_count: got %0d expected 3", fetch_count); end
    bus.inst_ready = 1'b0;
  endtask

  task automatic test_ack_delay();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(32'h0); bus.inst_ready = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    tick();
    bus.inst_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks += 3;
      if (bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL t2_req_c%0d: got %b expected 1", k, bus.imem_req); end
      if (bus.imem_addr !== 32'h4) begin errors++; $display("[TB] FAIL t2_addr_c%0d: got %h expected 4", k, bus.imem_addr); end
      if (bus.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL t2_valid_c%0d: got %b expected 0", k, bus.inst_valid); end
      if (k == 3) begin bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(32'h4); end
      tick();
    end
    bus.imem_ack = 1'b0;
    checks += 2;
    if (bus.inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL t2_valid_after: got %b expected 1", bus.inst_valid); end
    if (bus.inst_pc !== 32'h4 || bus.inst !== mem_word(32'h4)) begin
      errors++; $display("[TB] FAIL t2_inst: got %h@%h expected %h@4", bus.inst, bus.inst_pc, mem_word(32'h4));
    end
  endtask

  task automatic test_redirect_in_req();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h100;
    tick();
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++; $display("[TB] FAIL t3_hold_addr: got %b/%h expected 1/0", bus.imem_req, bus.imem_addr);
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(32'h0);
    tick();
    bus.imem_ack = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL t3_gap: got req %b valid %b expected 0 0", bus.imem_req, bus.inst_valid);
    end
    tick();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 || bus.inst_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL t3_new_req: got %b/%h/%b expected 1/100/0", bus.imem_req, bus.imem_addr, bus.inst_valid);
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(32'h100);
    tick();
    bus.imem_ack = 1'b0;
    checks++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h100) begin
      errors++; $display("[TB] FAIL t3_inst: got %b@%h expected 1@100", bus.inst_valid, bus.inst_pc);
    end
  endtask

  task automatic test_redirect_in_hold();
    bit found = 1'b0;
    do_reset();
    mem_auto = 1'b1; bus.inst_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int cyc = 0; cyc < 40 && !found; cyc++) begin
      if (bus.inst_valid && bus.inst_pc == 32'h8) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL t4_timeout: got no HOLD at 8 expected one"); end
    checks++;
    if (fetch_count !== CNT_W'(2)) begin errors++; $display("[TB] FAIL t4_count_before: got %0d expected 2", fetch_count); end
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h40;
    tick();
    bus.redirect_valid = 1'b0; bus.inst_ready = 1'b0;
    checks += 2;
    if (fetch_count !== CNT_W'(3)) begin errors++; $display("[TB] FAIL t4_count_after: got %0d expected 3", fetch_count); end
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
      errors++; $display("[TB] FAIL t4_next_addr: got %b/%h expected 1/40", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_pc_wrap();
    bit found = 1'b0;
    do_reset();
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    mem_auto = 1'b1; bus.inst_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      if (bus.inst_valid) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found || bus.inst_pc !== 32'hFFFF_FFFC) begin
      errors++; $display("[TB] FAIL wrap_inst_pc: got %h expected fffffffc", bus.inst_pc);
    end
    tick();
    bus.inst_ready = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++; $display("[TB] FAIL wrap_addr: got %b/%h expected 1/0", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_halt_and_reset();
    bit found = 1'b0;
    do_reset();
    mem_auto = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      if (bus.inst_valid) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL t5_timeout: got no inst_valid expected one"); end
    halt = 1'b1; bus.inst_ready = 1'b1;
    tick();
    halt = 1'b0; bus.inst_ready = 1'b0;
    checks += 2;
    if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL t5_halt: got req %b valid %b busy %b expected 0 0 0", bus.imem_req, bus.inst_valid, busy);
    end
    if (fetch_count !== CNT_W'(1)) begin errors++; $display("[TB] FAIL t5_count: got %0d expected 1", fetch_count); end
    start = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_target = 32'h200;
    repeat (3) tick();
    start = 1'b0; bus.redirect_valid = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b0 || busy !== 1'b0 || bus.imem_addr !== 32'h4) begin
      errors++; $display("[TB] FAIL t5_halt_sticky: got %b/%b/%h expected 0/0/4", bus.imem_req, busy, bus.imem_addr);
    end
    do_reset();
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h300;
    tick();
    bus.redirect_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h300) begin
      errors++; $display("[TB] FAIL t5_req300: got %b/%h expected 1/300", bus.imem_req, bus.imem_addr);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(32'h300);
    tick();
    bus.imem_ack = 1'b0;
    checks++;
    if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.imem_addr !== RESET_PC || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL t5_late_ack: got valid %b req %b addr %h busy %b expected 0 0 %h 0",
                         bus.inst_valid, bus.imem_req, bus.imem_addr, busy, RESET_PC);
    end
  endtask

  task automatic test_misaligned_redirect();
    do_reset();
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h102;
    tick();
    bus.redirect_valid = 1'b0;
`ifdef PCSEQ_ALIGN_CHECK_EN
    checks++;
    if (misalign_err !== 1'b1 || bus.imem_addr !== RESET_PC) begin
      errors++; $display("[TB] FAIL t6_pulse: got err %b addr %h expected 1 %h", misalign_err, bus.imem_addr, RESET_PC);
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (misalign_err !== 1'b0 || bus.imem_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL t6_halt: got err %b req %b busy %b expected 0 0 0", misalign_err, bus.imem_req, busy);
    end
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h102;
    tick();
    bus.redirect_valid = 1'b0;
    checks++;
    if (misalign_err !== 1'b1 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++; $display("[TB] FAIL t6_inflight: got err %b req %b addr %h expected 1 1 0", misalign_err, bus.imem_req, bus.imem_addr);
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(32'h0);
    tick();
    bus.imem_ack = 1'b0;
    checks++;
    if (misalign_err !== 1'b0 || bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL t6_drop_halt: got err %b req %b valid %b busy %b expected 0 0 0 0",
                         misalign_err, bus.imem_req, bus.inst_valid, busy);
    end
`else
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
      errors++; $display("[TB] FAIL t6_forced_align: got %b/%h expected 1/100", bus.imem_req, bus.imem_addr);
    end
`endif
  endtask

  // Reference model: the instruction stream decode should see, tracked as an expected PC and a handshake count.
  task automatic test_random_stream();
    logic [31:0] exp_pc;
    logic [31:0] prev_addr = '0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    int          model_cnt = 0;
    do_reset();
    mem_auto = 1'b1; lat_rand = 1'b1; lat = $urandom_range(0, 3);
    exp_pc = RESET_PC;
    start = 1'b1; tick(); start = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.redirect_valid = 1'b0;
      if (bus.imem_req) begin
        checks++;
        if (bus.imem_addr !== exp_pc) begin
          errors++; $display("[TB] FAIL rnd_addr: got %h expected %h", bus.imem_addr, exp_pc);
        end
        if (prev_req && !prev_ack) begin
          checks++;
          if (bus.imem_addr !== prev_addr) begin
            errors++; $display("[TB] FAIL rnd_addr_stable: got %h expected %h", bus.imem_addr, prev_addr);
          end
        end
      end
      prev_req = bus.imem_req; prev_ack = bus.imem_ack; prev_addr = bus.imem_addr;
      bus.inst_ready = 1'($urandom_range(0, 1));
      if (bus.inst_valid) begin
        checks += 2;
        if (bus.inst_pc !== exp_pc) begin
          errors++; $display("[TB] FAIL rnd_inst_pc: got %h expected %h", bus.inst_pc, exp_pc);
        end
        if (bus.inst !== mem_word(exp_pc)) begin
          errors++; $display("[TB] FAIL rnd_inst: got %h expected %h", bus.inst, mem_word(exp_pc));
        end
        if ($urandom_range(0, 4) == 0) begin
          bus.redirect_valid  = 1'b1;
          bus.redirect_target = $urandom & 32'hFFFF_FFFC;
          if (bus.inst_ready) model_cnt++;
          exp_pc = bus.redirect_target;
        end else if (bus.inst_ready) begin
          model_cnt++;
          exp_pc = exp_pc + 32'd4;
        end
      end
      tick();
    end
    checks++;
    if (fetch_count !== CNT_W'(model_cnt)) begin
      errors++; $display("[TB] FAIL rnd_count: got %0d expected %0d", fetch_count, CNT_W'(model_cnt));
    end
    bus.inst_ready = 1'b0; bus.redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential_fetch();
    test_ack_delay();
    test_redirect_in_req();
    test_redirect_in_hold();
    test_pc_wrap();
    test_halt_and_reset();
    test_misaligned_redirect();
    test_random_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
